// File: rtl/buffer_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : buffer_scanner
//  Description : Walks a character buffer from address 0 up to the write
//                cursor. Each character is fetched with a one-cycle read
//                strobe, then held on out_data under a valid/ready handshake.
//                One character is delivered every 3 cycles when the consumer
//                never stalls. A one-cycle done pulse marks the end of a scan.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK        in   1       clock, rising edge
//    CLR_N      in   1       asynchronous active-low reset
//    start      in   1       begin a scan from address 0 (ignored while busy)
//    end_addr   in   ADDR_W  number of valid characters (0 = empty)
//    abort      in   1       cancel the scan in progress, no done pulse
//    rd_en      out  1       buffer read strobe
//    rd_addr    out  ADDR_W  buffer read address
//    rd_data    in   DATA_W  buffer data, valid 1 cycle after rd_en
//    out_data   out  DATA_W  scanned character
//    out_valid  out  1       out_data qualifier
//    out_ready  in   1       consumer accepts out_data
//    busy       out  1       scanner is not idle
//    done       out  1       one-cycle pulse at scan completion
// ============================================================================
module buffer_scanner #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        WAIT    = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   len;
    logic [ADDR_W-1:0]   addr_inc;
    logic [DATA_W-1:0]   data_q;
    logic                launch;
    logic                xfer;

    // A scan launches only from IDLE; abort takes priority over start.
    assign launch   = (state == IDLE) && start && !abort;
    assign xfer     = (state == PRESENT) && out_ready;
    // The length is at most 2**ADDR_W-1, so the counter never wraps.
    assign addr_inc = addr + {{(ADDR_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // end_addr is the value being latched into len on this
                // same edge, so testing it here equals testing len.
                if (launch) begin
                    state_nxt = (end_addr != '0) ? READ : DONE;
                end
            end
            READ:    state_nxt = WAIT;
            WAIT:    state_nxt = PRESENT;
            PRESENT: begin
                if (out_ready) begin
                    state_nxt = (addr_inc == len) ? DONE : READ;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: length latch, address counter, output data register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            len    <= '0;
            addr   <= '0;
            data_q <= '0;
        end else begin
            if (launch) begin
                len  <= end_addr;
                addr <= '0;
            end
            // rd_data belongs to the READ issued one cycle earlier.
            if (state == WAIT) begin
                data_q <= rd_data;
            end
            if (xfer) begin
                addr <= addr_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state; reset forces state to IDLE, so every
    // strobe drops immediately while CLR_N is low.
    // ------------------------------------------------------------------
    assign rd_en     = (state == READ);
    // Address is only driven during the read strobe, so the post-increment
    // value left in the counter after the last character is never exposed.
    assign rd_addr   = rd_en ? addr : '0;
    assign out_data  = data_q;
    assign out_valid = (state == PRESENT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_buffer_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_buffer_scanner
//  Description : Self-checking bench for buffer_scanner. Expected characters
//                (and, for unstalled scans, their arrival cycle) are queued
//                when a scan is started and compared as transfers occur.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_scanner;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              CLK;
    logic              CLR_N;
    logic              start;
    logic [ADDR_W-1:0] end_addr;
    logic              abort;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    buffer_scanner #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK       (CLK),
        .CLR_N     (CLR_N),
        .start     (start),
        .end_addr  (end_addr),
        .abort     (abort),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    logic [DATA_W-1:0] mem [16];
    exp_t              sb [$];
    int                n_checks  = 0;
    int                n_errors  = 0;
    int                cyc       = 0;
    int                start_cyc = 0;
    int                exp_done_cyc = -1;
    int                scan_len  = 0;
    int                done_cnt  = 0;
    int                xfer_cnt  = 0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Buffer model: registered read, data valid the cycle after rd_en.
    always @(posedge CLK) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard consumer, sampled on the falling edge.
    always @(negedge CLK) begin
        exp_t e;
        if (CLR_N) begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
            end
            prev_stall = out_valid && !out_ready && !abort;
            prev_data  = out_data;
            if (rd_en) check("rd_addr_range", 32'(rd_addr < scan_len), 32'd1);
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    if (e.cyc >= 0) check("out_cyc", 32'(cyc), 32'(e.cyc));
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_done_cyc >= 0) check("done_cyc", 32'(cyc), 32'(exp_done_cyc));
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic pulse_start(input int n);
        end_addr  = ADDR_W'(n);
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge CLK); #1;
        start     = 1'b0;
    endtask

    // Queue the expected characters; timed scans also fix the arrival cycle.
    task automatic push_scan(input int n, input bit timed);
        for (int k = 0; k < n; k++) begin
            sb.push_back('{data: mem[k], cyc: timed ? start_cyc + 3 * (k + 1) : -1});
        end
        exp_done_cyc = timed ? start_cyc + 3 * n + 1 : -1;
    endtask

    // Wait for the next done pulse; optionally stall the consumer for
    // stall_len valid cycles on character index stall_at.
    task automatic wait_done(input int budget, input int stall_at, input int stall_len);
        int d0   = done_cnt;
        int x0   = xfer_cnt;
        int left = stall_len;
        for (int c = 0; c < budget; c++) begin
            @(posedge CLK); #1;
            if (done_cnt != d0) break;
            if (stall_at >= 0 && (xfer_cnt - x0) == stall_at && left > 0) begin
                out_ready = 1'b0;
                if (out_valid) left--;
            end else begin
                out_ready = 1'b1;
            end
        end
        out_ready = 1'b1;
        check("done_seen", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h41 + 8'(i);
        CLR_N     = 1'b0;
        start     = 1'b0;
        end_addr  = '0;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        CLR_N = 1'b1;
        @(posedge CLK); #1;

        // Three-character scan, consumer always ready.
        scan_len = 3;
        d0 = done_cnt;
        pulse_start(3);
        push_scan(3, 1'b1);
        wait_done(60, -1, 0);
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);
        check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Empty buffer: only a done pulse one cycle after start.
        scan_len = 0;
        pulse_start(0);
        push_scan(0, 1'b1);
        wait_done(20, -1, 0);
        check("t2_busy_low", 32'(busy), 32'd0);

        // Full 15-character scan with a 5-cycle stall on character 7.
        scan_len = 15;
        pulse_start(15);
        push_scan(15, 1'b0);
        wait_done(300, 7, 5);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Abort during presentation of the second character.
        scan_len = 5;
        d0 = done_cnt;
        pulse_start(5);
        sb.push_back('{data: mem[0], cyc: start_cyc + 3});
        exp_done_cyc = -1;
        while (cyc < start_cyc + 4) begin @(posedge CLK); #1; end
        out_ready = 1'b0;
        while (cyc < start_cyc + 6) begin @(posedge CLK); #1; end
        check("t4_valid_pre_abort", 32'(out_valid), 32'd1);
        abort = 1'b1;
        @(posedge CLK); #1;
        abort     = 1'b0;
        out_ready = 1'b1;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_out_valid", 32'(out_valid), 32'd0);
        check("t4_rd_en", 32'(rd_en), 32'd0);
        repeat (5) @(posedge CLK);
        #1;
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);
        scan_len = 3;
        pulse_start(3);
        push_scan(3, 1'b1);
        wait_done(60, -1, 0);

        // Abort together with start in IDLE: nothing begins.
        abort = 1'b1;
        pulse_start(4);
        abort = 1'b0;
        check("t4b_busy", 32'(busy), 32'd0);

        // Asynchronous reset between edges in the middle of a scan.
        scan_len = 5;
        d0 = done_cnt;
        pulse_start(5);
        push_scan(5, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        check("t5_pre_busy", 32'(busy), 32'd1);
        #2 CLR_N = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_rd_en", 32'(rd_en), 32'd0);
        check("t5_rd_addr", 32'(rd_addr), 32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_out_data", 32'(out_data), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        sb.delete();
        exp_done_cyc = -1;
        @(posedge CLK); #1;
        CLR_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("t5_idle_after", 32'(busy), 32'd0);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        scan_len = 3;
        pulse_start(3);
        push_scan(3, 1'b1);
        wait_done(60, -1, 0);

        // start re-pulsed while busy and end_addr changed mid-scan.
        scan_len = 3;
        d0 = done_cnt;
        pulse_start(3);
        push_scan(3, 1'b1);
        end_addr = 4'd9;
        @(posedge CLK); #1;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        while (cyc < start_cyc + 6) begin @(posedge CLK); #1; end
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        wait_done(60, -1, 0);
        repeat (4) @(posedge CLK);
        #1;
        check("t6_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);
        check("t6_busy_low", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
